// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: load-use stalls, multi-cycle branch flush,
// per-source forwarding selects and saturating stall/flush statistics.
module hazard_ctrl_unit #(
    parameter int ADDR_W      = 5,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      ex_valid,
    input  logic                      ex_wb_en,
    input  logic [ADDR_W-1:0]         ex_wb_addr,
    input  logic                      ex_is_load,
    input  logic                      ex_branch_taken,
    input  logic                      dm_valid,
    input  logic                      dm_wb_en,
    input  logic [ADDR_W-1:0]         dm_wb_addr,
    output logic                      pc_hold,
    output logic                      if_id_hold,
    output logic                      id_ex_bubble,
    output logic                      if_id_flush,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_count,
    output logic [CNT_W-1:0]          flush_count,
    output logic                      busy
);

    localparam int MAX_LEN = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
    localparam int CW      = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic [NUM_SRC-1:0] lu_hit;
    logic               ex_fwd_ok;
    logic               dm_fwd_ok;
    logic               lu;
    logic               br;
    logic               hold_c;
    logic               bubble_c;
    logic               flush_c;
    logic               br_event;

    // A load's result is not available in EX, so it never forwards from there.
    assign ex_fwd_ok = ex_valid & ex_wb_en & ~ex_is_load;
    assign dm_fwd_ok = dm_valid & dm_wb_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [ADDR_W-1:0] src_addr;
            logic              src_live;
            logic              ex_hit;
            logic              dm_hit;

            assign src_addr = id_src_addr[gi*ADDR_W +: ADDR_W];
            assign src_live = id_src_used[gi] & (src_addr != '0);
            assign ex_hit   = src_live & ex_fwd_ok & (src_addr == ex_wb_addr);
            assign dm_hit   = src_live & dm_fwd_ok & (src_addr == dm_wb_addr);
            assign lu_hit[gi] = src_live & (src_addr == ex_wb_addr);

            assign fwd_sel[2*gi +: 2] = ex_hit ? 2'b01 :
                                        dm_hit ? 2'b10 : 2'b00;
        end
    endgenerate

    assign lu = id_valid & ex_valid & ex_wb_en & ex_is_load & (|lu_hit);
    assign br = ex_valid & ex_branch_taken;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_c   = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        br_event = 1'b0;
        case (state_q)
            S_FLUSH: begin
                // EX holds a bubble here, so a taken-branch flag is ignored.
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (br) begin
                    // A taken branch wins and discards any pending stall.
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    br_event = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d = S_FLUSH;
                        cnt_d   = CW'(FLUSH_DEPTH - 1);
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end else if (state_q == S_STALL) begin
                    hold_c   = 1'b1;
                    bubble_c = 1'b1;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end else if (lu) begin
                    hold_c   = 1'b1;
                    bubble_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = S_STALL;
                        cnt_d   = CW'(LOAD_LAT - 1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (hold_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (br_event && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Gating with rst_n keeps control outputs low for the whole reset window,
    // even while the RUN-state decode sees hazardous inputs.
    assign pc_hold      = rst_n & hold_c;
    assign if_id_hold   = rst_n & hold_c;
    assign id_ex_bubble = rst_n & bubble_c;
    assign if_id_flush  = rst_n & flush_c;
    assign busy         = (state_q != S_RUN);
    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding, load-use stall, branch flush,
// counter saturation and asynchronous reset during a stall.
module tb_hazard_ctrl_unit;

    localparam int ADDR_W = 5;
    localparam int NUM_SRC = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      ex_valid;
    logic                      ex_wb_en;
    logic [ADDR_W-1:0]         ex_wb_addr;
    logic                      ex_is_load;
    logic                      ex_branch_taken;
    logic                      dm_valid;
    logic                      dm_wb_en;
    logic [ADDR_W-1:0]         dm_wb_addr;

    logic                 pc_hold, if_id_hold, id_ex_bubble, if_id_flush, busy;
    logic [2*NUM_SRC-1:0] fwd_sel;
    logic [15:0]          stall_count, flush_count;

    logic                 s_pc_hold, s_if_id_hold, s_id_ex_bubble, s_if_id_flush, s_busy;
    logic [2*NUM_SRC-1:0] s_fwd_sel;
    logic [1:0]           s_stall_count, s_flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
        .ex_wb_addr(ex_wb_addr), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .dm_valid(dm_valid), .dm_wb_en(dm_wb_en), .dm_wb_addr(dm_wb_addr),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .fwd_sel(fwd_sel), .stall_count(stall_count),
        .flush_count(flush_count), .busy(busy)
    );

    hazard_ctrl_unit #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
        .ex_wb_addr(ex_wb_addr), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .dm_valid(dm_valid), .dm_wb_en(dm_wb_en), .dm_wb_addr(dm_wb_addr),
        .pc_hold(s_pc_hold), .if_id_hold(s_if_id_hold), .id_ex_bubble(s_id_ex_bubble),
        .if_id_flush(s_if_id_flush), .fwd_sel(s_fwd_sel), .stall_count(s_stall_count),
        .flush_count(s_flush_count), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {pc_hold, if_id_hold, id_ex_bubble, if_id_flush, busy}.
    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, pc_hold, if_id_hold, id_ex_bubble, if_id_flush, busy}, {27'd0, exp});
    endtask

    task automatic idle();
        id_valid = 0; id_src_addr = '0; id_src_used = '0;
        ex_valid = 0; ex_wb_en = 0; ex_wb_addr = '0; ex_is_load = 0; ex_branch_taken = 0;
        dm_valid = 0; dm_wb_en = 0; dm_wb_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        id_valid = 1; id_src_addr = {5'd7, 5'd0}; id_src_used = 2'b10;
        ex_valid = 1; ex_wb_en = 1; ex_wb_addr = 5'd7; ex_is_load = 1;
    endtask

    task automatic set_br();
        ex_valid = 1; ex_branch_taken = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        #12;
        chk_ctrl("reset_ctrl", 5'b00000);
        chk("reset_stall_cnt", {16'd0, stall_count}, 32'd0);
        chk("reset_flush_cnt", {16'd0, flush_count}, 32'd0);
        next_cycle();
        rst_n = 1;
        next_cycle();

        // Forwarding
        ex_valid = 1; ex_wb_en = 1; ex_wb_addr = 5'd5;
        dm_valid = 1; dm_wb_en = 1; dm_wb_addr = 5'd5;
        id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
        #2; chk("fwd_ex_prio", {28'd0, fwd_sel}, 32'b0001);
        ex_wb_addr = 5'd9;
        #2; chk("fwd_dm", {28'd0, fwd_sel}, 32'b0010);
        id_src_addr = '0; ex_wb_addr = 5'd0; dm_wb_addr = 5'd0; id_src_used = 2'b11;
        #2; chk("fwd_r0", {28'd0, fwd_sel}, 32'b0000);
        id_src_addr = {5'd5, 5'd3}; ex_wb_addr = 5'd3; dm_wb_addr = 5'd5;
        #2; chk("fwd_mixed", {28'd0, fwd_sel}, 32'b1001);
        id_src_used = 2'b00;
        #2; chk("fwd_unused", {28'd0, fwd_sel}, 32'b0000);
        id_src_addr = {5'd0, 5'd3}; id_src_used = 2'b01; ex_is_load = 1; dm_wb_addr = 5'd3;
        #2; chk("fwd_load_no_ex", {28'd0, fwd_sel}, 32'b0010);
        chk_ctrl("no_lu_when_id_invalid", 5'b00000);
        idle();
        next_cycle();

        // Load-use stall, LOAD_LAT=3
        set_lu();
        #2; chk_ctrl("lu_c1", 5'b11100);
        chk("lu_c1_cnt", {16'd0, stall_count}, 32'd0);
        next_cycle(); idle();
        #2; chk_ctrl("lu_c2", 5'b11101);
        next_cycle();
        #2; chk_ctrl("lu_c3", 5'b11101);
        chk("lu_c3_cnt", {16'd0, stall_count}, 32'd2);
        next_cycle();
        #2; chk_ctrl("lu_done", 5'b00000);
        chk("lu_stall_cnt", {16'd0, stall_count}, 32'd3);

        // Load-use, then a taken branch on the second STALL-state cycle
        set_lu();
        #2; chk_ctrl("lubr_c1", 5'b11100);
        next_cycle(); idle();
        #2; chk_ctrl("lubr_c2", 5'b11101);
        next_cycle(); set_br();
        #2; chk_ctrl("lubr_br", 5'b00111);
        next_cycle();
        #2; chk_ctrl("lubr_flush2", 5'b00111);
        chk("lubr_flush_cnt", {16'd0, flush_count}, 32'd1);
        next_cycle(); idle();
        #2; chk_ctrl("lubr_done", 5'b00000);
        chk("lubr_stall_cnt", {16'd0, stall_count}, 32'd5);

        // Load-use and branch in the same RUN cycle
        set_lu(); set_br();
        #2; chk_ctrl("same_cycle", 5'b00110);
        next_cycle(); idle();
        #2; chk_ctrl("same_cycle_flush2", 5'b00111);
        next_cycle();
        #2; chk_ctrl("same_cycle_done", 5'b00000);
        chk("same_flush_cnt", {16'd0, flush_count}, 32'd2);
        chk("same_stall_cnt", {16'd0, stall_count}, 32'd5);
        chk("sat_stall_cnt", {30'd0, s_stall_count}, 32'd3);

        // Three more branches: five in total
        for (int k = 0; k < 3; k++) begin
            set_br();
            next_cycle(); idle();
            next_cycle();
        end
        #2;
        chk("five_br_flush_cnt", {16'd0, flush_count}, 32'd5);
        chk("sat_flush_cnt", {30'd0, s_flush_count}, 32'd3);

        // Asynchronous reset during the second stall cycle
        set_lu();
        next_cycle(); idle();
        #2; chk_ctrl("rst_pre", 5'b11101);
        rst_n = 0;
        #1; chk_ctrl("rst_async", 5'b00000);
        chk("rst_async_cnt", {16'd0, stall_count}, 32'd0);
        next_cycle();
        rst_n = 1;
        next_cycle();
        #2; chk_ctrl("rst_after", 5'b00000);
        chk("rst_after_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_after_flush", {16'd0, flush_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
